// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: rounding-mode encodings, default widths,
// the rounded-result record handed to the post-round normalizer, and effective-rm selection.
package fpu_pkg;

    localparam int FPU_EXP_W = 9;
    localparam int FPU_MAN_W = 24;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [2:0] RM_DYN = 3'd7;

    typedef struct packed {
        logic                 sign;
        logic [FPU_EXP_W-1:0] exp;
        logic [FPU_MAN_W:0]   man;
    } round_result_t;

    // DYN in the instruction defers to the frm CSR; anything left over is checked later.
    function automatic logic [2:0] effective_rm(input logic [2:0] inst_rm,
                                                input logic [2:0] csr_frm);
        return (inst_rm == RM_DYN) ? csr_frm : inst_rm;
    endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Combinational round-increment decision from effective rm, sign, mantissa lsb and G/R/S.
// Shared with the int-to-float converter.
module fp_round_inc
    import fpu_pkg::*;
(
    input  logic [2:0] rm_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic [2:0] grs_i,
    output logic       inc_o,
    output logic       inexact_o,
    output logic       illegal_o
);

    logic g, r, s;
    logic rne_inc;

    assign g         = grs_i[2];
    assign r         = grs_i[1];
    assign s         = grs_i[0];
    assign inexact_o = g | r | s;
    assign rne_inc   = g & (r | s | lsb_i);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        inc_o     = 1'b0;
        illegal_o = 1'b0;
        case (rm_i)
            RM_RNE: inc_o = rne_inc;
            RM_RTZ: inc_o = 1'b0;
            RM_RDN: inc_o = inexact_o & sign_i;
            RM_RUP: inc_o = inexact_o & ~sign_i;
            RM_RMM: inc_o = g;
            default: begin
                // Reserved encodings still produce a defined result (RNE) and are flagged.
                inc_o     = rne_inc;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fp_round_stage.sv
// Registered rounding stage: applies the RISC-V rounding mode to a pre-normalized operand
// and presents the result on a one-deep valid/ready register, plus a sticky NX flag.
module fp_round_stage
    import fpu_pkg::*;
#(
    parameter int EXP_W = FPU_EXP_W,
    parameter int MAN_W = FPU_MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_man,
    input  logic [2:0]       in_grs,
    input  logic             in_special,
    input  logic             done_cal_in,
    input  logic [2:0]       inst_rm,
    input  logic [2:0]       csr_frm,
    input  logic             out_ready,
    output logic             rounded_result_sign,
    output logic [EXP_W-1:0] rounded_result_exp,
    output logic [MAN_W:0]   rounded_result_man,
    output logic             round_flag,
    output logic             done_cal,
    output logic             out_valid,
    output logic             illegal_rm,
    output logic             nx_sticky,
    input  logic             nx_clr
);

    logic             valid_q, valid_d;
    logic             sign_q,  sign_d;
    logic [EXP_W-1:0] exp_q,   exp_d;
    logic [MAN_W:0]   man_q,   man_d;
    logic             flag_q,  flag_d;
    logic             ill_q,   ill_d;
    logic             done_q,  done_d;
    logic             nx_q,    nx_d;

    logic             accept;
    logic             inc_raw, inc, inexact, illegal;
    logic             flag_next;
    logic [MAN_W:0]   man_next;

    fp_round_inc u_inc (
        .rm_i      (effective_rm(inst_rm, csr_frm)),
        .sign_i    (in_sign),
        .lsb_i     (in_man[0]),
        .grs_i     (in_grs),
        .inc_o     (inc_raw),
        .inexact_o (inexact),
        .illegal_o (illegal)
    );

    // Specials (Inf/NaN/zero) pass through untouched and never raise inexact.
    assign inc       = inc_raw & ~in_special;
    assign flag_next = inexact & ~in_special;
    assign man_next  = {1'b0, in_man} + {{MAN_W{1'b0}}, inc};

    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        man_d   = man_q;
        flag_d  = flag_q;
        ill_d   = ill_q;
        done_d  = done_q;
        nx_d    = (nx_clr ? 1'b0 : nx_q) | (accept & flag_next);

        if (accept) begin
            valid_d = 1'b1;
            sign_d  = in_sign;
            exp_d   = in_exp;
            man_d   = man_next;
            flag_d  = flag_next;
            ill_d   = illegal;
            done_d  = done_cal_in;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the
        // pre-edge values; the datapath register is reset too because its fields are
        // visible outputs that must read zero out of reset.
        if (rst) begin
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            man_q   <= '0;
            flag_q  <= 1'b0;
            ill_q   <= 1'b0;
            done_q  <= 1'b0;
            nx_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            man_q   <= man_d;
            flag_q  <= flag_d;
            ill_q   <= ill_d;
            done_q  <= done_d;
            nx_q    <= nx_d;
        end
    end

    assign out_valid           = valid_q;
    assign rounded_result_sign = sign_q;
    assign rounded_result_exp  = exp_q;
    assign rounded_result_man  = man_q;
    assign round_flag          = flag_q;
    assign illegal_rm          = ill_q;
    assign done_cal            = done_q & valid_q;
    assign nx_sticky           = nx_q;

endmodule

// File: doc/fp_round_stage.md
Name: fp_round_stage

Overview:
- Registered rounding stage of the single-precision FPU, sitting directly upstream of the post-round normalizer.
- Takes a pre-normalized sign/exponent/24-bit mantissa plus guard/round/sticky bits from the arithmetic datapath and applies the RISC-V rounding mode.
- Presents the rounded sign/exponent/25-bit mantissa (bit 24 = rounding carry) and an inexact flag on a one-deep valid/ready output register.
- Also accumulates a sticky NX flag for fflags.

Parameters:
- EXP_W, 9, exponent width including overflow bit.
- MAN_W, 24, mantissa width including hidden bit; the output mantissa is MAN_W+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream has a valid operand.
- in_ready  out  1  stage can accept this cycle.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W  biased exponent.
- in_man  in  MAN_W  normalized mantissa, hidden bit at MSB.
- in_grs  in  3  guard, round, sticky (bit2 = G).
- in_special  in  1  Inf/NaN/zero; bypasses rounding.
- done_cal_in  in  1  calculation-done tag, travels with the operand.
- inst_rm  in  3  instruction rm field.
- csr_frm  in  3  frm CSR value, used when inst_rm = 3'b111.
- out_ready  in  1  downstream consumes the output this cycle.
- rounded_result_sign  out  1  registered sign.
- rounded_result_exp  out  EXP_W  registered exponent, unchanged by rounding.
- rounded_result_man  out  MAN_W+1  {carry, rounded mantissa}.
- round_flag  out  1  result inexact (this operand).
- done_cal  out  1  registered done_cal_in, qualified by out_valid.
- out_valid  out  1  output register holds a result.
- illegal_rm  out  1  effective rm reserved (5, 6, or DYN with csr_frm of 5/6/7).
- nx_sticky  out  1  accumulated inexact.
- nx_clr  in  1  clear nx_sticky (fflags write).

Behaviour:
- Reset (synchronous, clk edge with rst = 1): all outputs 0; out_valid = 0; nx_sticky = 0. Reset mid-transaction drops the held result; no partial output.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept when in_valid & in_ready; the result appears on the next edge with out_valid = 1. Latency is 1 cycle.
  - Output fields hold stable while out_valid & !out_ready.
  - Simultaneous consume and accept: the register reloads and out_valid stays 1, giving full throughput.
  - Consume without accept: out_valid becomes 0.
  - Data is never dropped or duplicated.
- Effective rm:
  - eff = (inst_rm == 7) ? csr_frm : inst_rm.
  - If eff is in {5, 6, 7}: round as RNE and register illegal_rm = 1 with that result. illegal_rm is valid only while out_valid.
- Rounding, with G = in_grs[2], R = in_grs[1], S = in_grs[0], lsb = in_man[0], inexact = G | R | S:
  - RNE (0): inc = G & (R | S | lsb).
  - RTZ (1): inc = 0.
  - RDN (2): inc = inexact & sign.
  - RUP (3): inc = inexact & !sign.
  - RMM (4): inc = G.
- Result: rounded_result_man = {1'b0, in_man} + inc, zero-extended to MAN_W+1.
  - Carry into bit 24 (e.g. in_man all-ones, inc = 1) yields 25'h1000000. Exponent is not adjusted here; renormalization belongs downstream.
- in_special = 1: inc forced 0, round_flag = 0, mantissa/exponent pass through unchanged.
- round_flag = inexact & !in_special, registered.
- nx_sticky next = (nx_clr ? 0 : nx_sticky) | (accept & round_flag_next). A set in the same cycle as a clear wins.
- No combinational path from in_* to out_* other than in_ready depending on out_ready.

Decomposition:
- Shared package fpu_pkg:
  - Rounding-mode localparams RM_RNE/RTZ/RDN/RUP/RMM/DYN.
  - EXP_W/MAN_W defaults.
  - Struct/typedef for the {sign, exp, man} rounded result, shared with the normalizer.
- One natural sub-module: fp_round_inc, the purely combinational increment-decision logic (eff rm, sign, lsb, grs -> inc, inexact, illegal). It is reused by the int-to-float converter.

Test Plan:
- RNE tie-to-even:
  - in_man = 24'hC00000, grs = 3'b100, rm = 0 -> man 25'h0C00000, round_flag = 1.
  - in_man = 24'hC00001, grs = 3'b100 -> 25'h0C00002.
- Carry-out: in_man = 24'hFFFFFF, grs = 3'b110, rm = 0, exp = 9'h07F -> man 25'h1000000, exp 9'h07F, round_flag = 1.
- Directed modes: sign = 1, in_man = 24'h800001, grs = 3'b001:
  - RDN -> 25'h0800002.
  - RUP -> 25'h0800001.
  - RTZ -> 25'h0800001.
  - RMM -> 25'h0800001.
  - round_flag = 1 in all four.
- DYN/illegal:
  - inst_rm = 7, csr_frm = 3 behaves as RUP.
  - inst_rm = 5, grs = 3'b100, in_man = 24'h800000 -> RNE result 25'h0800000, illegal_rm = 1.
- Backpressure: 3 back-to-back operands with out_ready low for 2 cycles after the first:
  - First output holds stable.
  - in_ready = 0.
  - All 3 results emerge in order, none lost.
  - nx_sticky = 1 after the first inexact; nx_clr and an inexact accept in the same cycle -> stays 1.
- Reset mid-flight: rst asserted with out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, nx_sticky = 0, round_flag = 0, in_ready = 1.
